// File: rtl/fu_complete_arbiter_pkg.sv
// Shared types and sizing for the FU-to-complete-stage arbiter.
package fu_complete_arbiter_pkg;

  localparam int SUPERSCALAR_WAYS  = 3;
  localparam int NUM_FU_RESULT_SRC = 8;

  typedef struct packed {
    logic        valid;
    logic        take_branch;
    logic [5:0]  pr_idx;
    logic [4:0]  rob_idx;
    logic [31:0] target_pc;
  } FU_COMPLETE_PACKET;

endpackage

// File: rtl/fu_complete_arbiter_rr_multi_select.sv
// Combinational rotating N-of-M picker: priority-masked requests first, then the rest,
// each pass scanning from rr_ptr; last_idx is the granted index furthest along the scan.
module rr_multi_select #(
  parameter int N    = 8,
  parameter int WAYS = 3,
  parameter int PW   = $clog2(N),
  parameter int CW   = $clog2(WAYS + 1)
) (
  input  logic [N-1:0]            occupied,
  input  logic [PW-1:0]           rr_ptr,
  input  logic [N-1:0]            prio_mask,
  output logic [WAYS-1:0][N-1:0]  lane_grant,
  output logic [PW-1:0]           last_idx,
  output logic [CW-1:0]           grant_count
);

  logic [PW-1:0] idx;
  logic [PW-1:0] last_off;
  logic [CW-1:0] cnt;

  always_comb begin
    lane_grant = '0;
    idx        = '0;
    last_off   = '0;
    cnt        = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(rr_ptr) + k) % N);
        if (occupied[idx] && (prio_mask[idx] == (pass == 0)) && (int'(cnt) < WAYS)) begin
          lane_grant[cnt][idx] = 1'b1;
          // Track scan distance, not grant order, so priority grants do not skew rotation.
          if (PW'(k) > last_off) last_off = PW'(k);
          cnt = cnt + CW'(1);
        end
      end
    end
    grant_count = cnt;
    last_idx    = PW'((int'(rr_ptr) + int'(last_off)) % N);
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// One-entry result slot per FU, drained to up to WAYS complete lanes by rotating priority.
// Optional FU_ARB_BRANCH_FIRST_EN: grant take_branch results ahead of the others.
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_RESULT_SRC,
  parameter int WAYS   = SUPERSCALAR_WAYS
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          squash,
  input  FU_COMPLETE_PACKET             fu_packet_in [NUM_FU],
  output logic [NUM_FU-1:0]             fu_ready_out,
  output FU_COMPLETE_PACKET             complete_fu_out [WAYS],
  output logic [$clog2(WAYS+1)-1:0]     grant_count
);

  localparam int PW = $clog2(NUM_FU);
  localparam int CW = $clog2(WAYS + 1);

  logic [NUM_FU-1:0]           slot_valid;
  FU_COMPLETE_PACKET           slot_pkt [NUM_FU];
  logic [PW-1:0]               rr_ptr;
  logic [PW-1:0]               last_idx;
  logic [PW-1:0]               next_ptr;
  logic [NUM_FU-1:0]           prio_mask;
  logic [NUM_FU-1:0]           grant;
  logic [NUM_FU-1:0]           capture;
  logic [WAYS-1:0][NUM_FU-1:0] lane_grant;
  logic [CW-1:0]               sel_count;

`ifdef FU_ARB_BRANCH_FIRST_EN
  always_comb begin
    prio_mask = '0;
    for (int i = 0; i < NUM_FU; i++) prio_mask[i] = slot_pkt[i].take_branch;
  end
`else
  assign prio_mask = '0;
`endif

  rr_multi_select #(.N(NUM_FU), .WAYS(WAYS)) u_select (
    .occupied    (slot_valid),
    .rr_ptr      (rr_ptr),
    .prio_mask   (prio_mask),
    .lane_grant  (lane_grant),
    .last_idx    (last_idx),
    .grant_count (sel_count)
  );

  always_comb begin
    grant = '0;
    for (int l = 0; l < WAYS; l++) begin
      grant              = grant | lane_grant[l];
      complete_fu_out[l] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (lane_grant[l][i]) complete_fu_out[l] = complete_fu_out[l] | slot_pkt[i];
      end
    end
  end

  assign grant_count  = sel_count;
  assign fu_ready_out = ~slot_valid | grant;
  assign next_ptr     = (last_idx == PW'(NUM_FU - 1)) ? '0 : last_idx + PW'(1);

  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_FU; i++) capture[i] = fu_packet_in[i].valid & fu_ready_out[i];
  end

  always_ff @(posedge clock) begin
    if (!reset_n || squash) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i])     slot_valid[i] <= 1'b1;
        else if (grant[i])  slot_valid[i] <= 1'b0;
      end
      if (sel_count != '0) rr_ptr <= next_ptr;
    end
  end

  // Payload needs no reset: it is only observed through a set slot_valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (capture[i]) slot_pkt[i] <= fu_packet_in[i];
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Self-checking bench for fu_complete_arbiter: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  localparam int N = NUM_FU_RESULT_SRC;
  localparam int W = SUPERSCALAR_WAYS;
`ifdef FU_ARB_BRANCH_FIRST_EN
  localparam bit BF = 1'b1;
`else
  localparam bit BF = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              squash = 1'b0;
  FU_COMPLETE_PACKET fu_packet_in [N];
  logic [N-1:0]      fu_ready_out;
  FU_COMPLETE_PACKET complete_fu_out [W];
  logic [1:0]        grant_count;

  int checks = 0;
  int errors = 0;

  fu_complete_arbiter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .squash          (squash),
    .fu_packet_in    (fu_packet_in),
    .fu_ready_out    (fu_ready_out),
    .complete_fu_out (complete_fu_out),
    .grant_count     (grant_count)
  );

  always #5 clock = ~clock;

  // Reference model: slot contents, pointer, and the grant list derived by filtering the scan order.
  bit                m_valid [N];
  FU_COMPLETE_PACKET m_pkt [N];
  int                m_ptr = 0;
  int                m_lane [W];
  int                m_n;
  int                m_last;
  bit                m_g [N];
  logic [N-1:0]      m_rdy;

  function automatic void m_pick();
    int scan[$];
    int order[$];
    int best;
    for (int k = 0; k < N; k++) scan.push_back((m_ptr + k) % N);
    foreach (scan[j]) if (m_valid[scan[j]] && BF && m_pkt[scan[j]].take_branch) order.push_back(scan[j]);
    foreach (scan[j]) if (m_valid[scan[j]] && !(BF && m_pkt[scan[j]].take_branch)) order.push_back(scan[j]);
    m_n = (order.size() < W) ? order.size() : W;
    best = -1;
    for (int i = 0; i < N; i++) m_g[i] = 1'b0;
    for (int l = 0; l < W; l++) m_lane[l] = -1;
    for (int l = 0; l < m_n; l++) begin
      m_lane[l] = order[l];
      m_g[order[l]] = 1'b1;
      if ((order[l] - m_ptr + N) % N > best) best = (order[l] - m_ptr + N) % N;
    end
    m_last = (m_ptr + best) % N;
    for (int i = 0; i < N; i++) m_rdy[i] = !m_valid[i] || m_g[i];
  endfunction

  always @(posedge clock) begin
    m_pick();
    if (!reset_n || squash) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (fu_packet_in[i].valid && m_rdy[i]) begin
          m_valid[i] = 1'b1;
          m_pkt[i]   = fu_packet_in[i];
        end else if (m_g[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (m_n > 0) m_ptr = (m_last + 1) % N;
    end
  end

  function automatic FU_COMPLETE_PACKET mk(bit v, bit br, int pr, int rob, int pc);
    FU_COMPLETE_PACKET p;
    p.valid       = v;
    p.take_branch = br;
    p.pr_idx      = 6'(pr);
    p.rob_idx     = 5'(rob);
    p.target_pc   = 32'(pc);
    return p;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) fu_packet_in[i] = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) fu_packet_in[i] = mk(1, 0, i, i, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    clear_inputs();
    checks++;
    if (grant_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", grant_count); end
    checks++;
    if (fu_ready_out !== 8'hFF) begin errors++; $display("FAIL reset_ready got %h want ff", fu_ready_out); end
    checks++;
    if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr); end
    for (int l = 0; l < W; l++) begin
      checks++;
      if (complete_fu_out[l] !== '0) begin errors++; $display("FAIL reset_lane%0d got %h want 0", l, complete_fu_out[l]); end
    end
  endtask

  task automatic test_single();
    fu_packet_in[2] = mk(1, 0, 17, 3, 32'h100);
    @(negedge clock);
    clear_inputs();
    checks++;
    if (grant_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", grant_count); end
    checks++;
    if (complete_fu_out[0].valid !== 1'b1 || complete_fu_out[0].pr_idx !== 6'd17)
      begin errors++; $display("FAIL single_lane0 got valid=%b pr=%0d want valid=1 pr=17", complete_fu_out[0].valid, complete_fu_out[0].pr_idx); end
    checks++;
    if (complete_fu_out[1] !== '0 || complete_fu_out[2] !== '0)
      begin errors++; $display("FAIL single_unused got %h/%h want 0", complete_fu_out[1], complete_fu_out[2]); end
    @(negedge clock);
    checks++;
    if (grant_count !== 2'd0) begin errors++; $display("FAIL single_drain got %0d want 0", grant_count); end
    checks++;
    if (dut.rr_ptr !== 3'd3) begin errors++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr); end
  endtask

  task automatic test_oversub();
    int exp_fu [3][3];
    int exp_n [3];
    logic [7:0] exp_rdy [3];
    int exp_ptr [3];
    exp_fu = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 0}};
    exp_n = '{3, 3, 2};
    exp_rdy = '{8'h07, 8'h3F, 8'hFF};
    exp_ptr = '{0, 3, 6};
    squash = 1'b1;
    @(negedge clock);
    squash = 1'b0;
    for (int i = 0; i < N; i++) fu_packet_in[i] = mk(1, 0, 40 + i, i, 0);
    @(negedge clock);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (grant_count !== 2'(exp_n[c])) begin errors++; $display("FAIL oversub_count c%0d got %0d want %0d", c, grant_count, exp_n[c]); end
      checks++;
      if (fu_ready_out !== exp_rdy[c]) begin errors++; $display("FAIL oversub_ready c%0d got %h want %h", c, fu_ready_out, exp_rdy[c]); end
      checks++;
      if (dut.rr_ptr !== 3'(exp_ptr[c])) begin errors++; $display("FAIL oversub_ptr c%0d got %0d want %0d", c, dut.rr_ptr, exp_ptr[c]); end
      for (int l = 0; l < exp_n[c]; l++) begin
        checks++;
        if (complete_fu_out[l].valid !== 1'b1 || complete_fu_out[l].rob_idx !== 5'(exp_fu[c][l]))
          begin errors++; $display("FAIL oversub_lane c%0d l%0d got rob=%0d want %0d", c, l, complete_fu_out[l].rob_idx, exp_fu[c][l]); end
      end
      @(negedge clock);
    end
    checks++;
    if (dut.rr_ptr !== 3'd0 || grant_count !== 2'd0)
      begin errors++; $display("FAIL oversub_wrap got ptr=%0d cnt=%0d want 0/0", dut.rr_ptr, grant_count); end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j <= 10; j++) begin
      if (j < 10) fu_packet_in[0] = mk(1, 0, 1, j, j);
      else        clear_inputs();
      checks++;
      if (fu_ready_out[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready j%0d got 0 want 1", j); end
      if (j > 0) begin
        checks++;
        if (grant_count !== 2'd1 || complete_fu_out[0].rob_idx !== 5'(j - 1))
          begin errors++; $display("FAIL b2b_lane j%0d got cnt=%0d rob=%0d want 1/%0d", j, grant_count, complete_fu_out[0].rob_idx, j - 1); end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_squash();
    foreach (fu_packet_in[i]) if (i inside {0, 1, 2, 3, 5}) fu_packet_in[i] = mk(1, 0, 20 + i, i, 0);
    @(negedge clock);
    clear_inputs();
    fu_packet_in[4] = mk(1, 0, 24, 4, 0);
    squash = 1'b1;
    checks++;
    if (grant_count !== 2'd3) begin errors++; $display("FAIL squash_cycle_count got %0d want 3", grant_count); end
    @(negedge clock);
    squash = 1'b0;
    clear_inputs();
    checks++;
    if (grant_count !== 2'd0 || fu_ready_out !== 8'hFF)
      begin errors++; $display("FAIL squash_empty got cnt=%0d rdy=%h want 0/ff", grant_count, fu_ready_out); end
    checks++;
    if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL squash_ptr got %0d want 0", dut.rr_ptr); end
    @(negedge clock);
    checks++;
    if (grant_count !== 2'd0) begin errors++; $display("FAIL squash_fu4_dropped got %0d want 0", grant_count); end
  endtask

  task automatic test_branch_first();
    int exp [3];
    exp = BF ? '{5, 0, 1} : '{0, 1, 2};
    for (int i = 0; i < 6; i++) fu_packet_in[i] = mk(1, i == 5, 30 + i, i, 0);
    @(negedge clock);
    clear_inputs();
    for (int l = 0; l < W; l++) begin
      checks++;
      if (complete_fu_out[l].rob_idx !== 5'(exp[l]))
        begin errors++; $display("FAIL branch_lane%0d got %0d want %0d", l, complete_fu_out[l].rob_idx, exp[l]); end
    end
    squash = 1'b1;
    @(negedge clock);
    squash = 1'b0;
  endtask

  task automatic test_random();
    FU_COMPLETE_PACKET cur [N];
    bit acc [N];
    for (int i = 0; i < N; i++) begin cur[i] = '0; acc[i] = 1'b1; end
    for (int c = 0; c < 400; c++) begin
      m_pick();
      checks++;
      if (grant_count !== 2'(m_n) || fu_ready_out !== m_rdy || dut.rr_ptr !== 3'(m_ptr))
        begin errors++; $display("FAIL rand_ctl c%0d got cnt=%0d rdy=%h ptr=%0d want %0d/%h/%0d", c, grant_count, fu_ready_out, dut.rr_ptr, m_n, m_rdy, m_ptr); end
      for (int l = 0; l < W; l++) begin
        checks++;
        if (l < m_n) begin
          if (complete_fu_out[l] !== m_pkt[m_lane[l]])
            begin errors++; $display("FAIL rand_lane c%0d l%0d got %h want %h", c, l, complete_fu_out[l], m_pkt[m_lane[l]]); end
        end else if (complete_fu_out[l] !== '0)
          begin errors++; $display("FAIL rand_lane c%0d l%0d got %h want 0", c, l, complete_fu_out[l]); end
      end
      squash = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (acc[i])
          cur[i] = mk($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom);
        fu_packet_in[i] = cur[i];
        acc[i] = squash || !cur[i].valid || m_rdy[i];
      end
      @(negedge clock);
    end
    squash = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_oversub();
    test_back_to_back();
    test_squash();
    test_branch_first();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
